// File: rtl/spi_xfer_seq.sv
// APB-side command sequencer for apb_spi_master: programs one SPI transfer, polls STATUS, returns result.
// Optional poll timeout enabled by defining SPI_XFER_SEQ_TIMEOUT_EN (limit set by POLL_MAX).
module spi_xfer_seq #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int POLL_MAX       = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_rd_i,
    input  logic [7:0]                req_cmd_i,
    input  logic [31:0]               req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic [1:0]                req_csn_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [31:0]               pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_SETUP       = 3'd1;
    localparam logic [2:0] S_ACCESS      = 3'd2;
    localparam logic [2:0] S_POLL_SETUP  = 3'd3;
    localparam logic [2:0] S_POLL_ACCESS = 3'd4;
    localparam logic [2:0] S_RESP        = 3'd5;

    localparam logic [2:0] STEP_CMD  = 3'd0;
    localparam logic [2:0] STEP_ADR  = 3'd1;
    localparam logic [2:0] STEP_LEN  = 3'd2;
    localparam logic [2:0] STEP_TX   = 3'd3;
    localparam logic [2:0] STEP_KICK = 3'd4;
    localparam logic [2:0] STEP_RX   = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  r_step;
    logic        r_rd;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_csn;
    logic        r_err;
    logic [31:0] r_rdata;

    logic [7:0]  w_off;
    logic [31:0] w_pwdata;
    logic        w_pwrite;
    logic [31:0] w_csnBit;
    logic        w_pollExpired;
    logic        w_pollBusy;

    assign w_csnBit   = 32'd1 << (4'd8 + {2'b00, r_csn});
    assign w_pollBusy = (r_state == S_POLL_ACCESS) && pready_i && !pslverr_i && !prdata_i[0];

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_MAX + 1);
    logic [PCW-1:0] r_pollCnt;

    // Counts non-idle STATUS polls of the current request; the POLL_MAX-th one aborts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pollCnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_pollCnt <= '0;
        end else if (w_pollBusy) begin
            r_pollCnt <= r_pollCnt + PCW'(1);
        end
    end

    assign w_pollExpired = (r_pollCnt == PCW'(POLL_MAX - 1));
`else
    assign w_pollExpired = 1'b0;
`endif

    // Address/data of the access in flight are decoded from the step, so they hold through wait states.
    always_comb begin
        w_off    = 8'h00;
        w_pwdata = 32'h0;
        w_pwrite = 1'b0;
        if (r_state == S_SETUP || r_state == S_ACCESS) begin
            case (r_step)
                STEP_CMD:  begin w_off = 8'h08; w_pwrite = 1'b1; w_pwdata = {r_cmd, 24'h0}; end
                STEP_ADR:  begin w_off = 8'h0C; w_pwrite = 1'b1; w_pwdata = r_addr; end
                STEP_LEN:  begin w_off = 8'h10; w_pwrite = 1'b1; w_pwdata = {16'd32, 8'd32, 8'd8}; end
                STEP_TX:   begin w_off = 8'h18; w_pwrite = 1'b1; w_pwdata = r_wdata; end
                STEP_KICK: begin
                    w_off    = 8'h00;
                    w_pwrite = 1'b1;
                    w_pwdata = w_csnBit | (r_rd ? 32'h1 : 32'h2);
                end
                STEP_RX:   w_off = 8'h20;
                default:   w_off = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_step  <= STEP_CMD;
            r_rd    <= 1'b0;
            r_cmd   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_csn   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_rd    <= req_rd_i;
                        r_cmd   <= req_cmd_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_csn   <= req_csn_i;
                        r_err   <= 1'b0;
                        r_rdata <= '0;
                        r_step  <= STEP_CMD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: r_state <= S_ACCESS;
                S_ACCESS: begin
                    if (pready_i) begin
                        if (pslverr_i) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else if (r_step == STEP_KICK) begin
                            r_state <= S_POLL_SETUP;
                        end else if (r_step == STEP_RX) begin
                            r_rdata <= prdata_i;
                            r_state <= S_RESP;
                        end else begin
                            // Reads have no TX word, so they jump from SPILEN straight to the kick.
                            r_step  <= (r_step == STEP_LEN && r_rd) ? STEP_KICK : r_step + 3'd1;
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_POLL_SETUP: r_state <= S_POLL_ACCESS;
                S_POLL_ACCESS: begin
                    if (pready_i) begin
                        if (pslverr_i) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else if (prdata_i[0]) begin
                            if (r_rd) begin
                                r_step  <= STEP_RX;
                                r_state <= S_SETUP;
                            end else begin
                                r_state <= S_RESP;
                            end
                        end else if (w_pollExpired) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_POLL_SETUP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign psel_o      = (r_state == S_SETUP) || (r_state == S_ACCESS) ||
                         (r_state == S_POLL_SETUP) || (r_state == S_POLL_ACCESS);
    assign penable_o   = (r_state == S_ACCESS) || (r_state == S_POLL_ACCESS);
    assign paddr_o     = APB_ADDR_WIDTH'(w_off);
    assign pwdata_o    = w_pwdata;
    assign pwrite_o    = w_pwrite;
    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

Command sequencer sitting on the APB side of the `apb_spi_master` peripheral. It accepts one SPI transaction request at a time (command byte, 32-bit address, one 32-bit data word) on a valid/ready port. It programs the SPI master through a fixed series of APB accesses, polls STATUS until the transfer finishes, and for reads fetches the RX word. It returns the result on a valid/ready response port, so firmware-free agents can drive SPI flash/peripherals without owning the APB bus.

## Interface
Parameters:
- `APB_ADDR_WIDTH`, 12, APB address width; matches the SPI master's 4 KB window.
- `POLL_MAX`, 1024, maximum STATUS polls before timeout; used only with the timeout macro.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  request accepted when high with valid
- `req_rd_i`  in  1  1 = SPI read, 0 = SPI write
- `req_cmd_i`  in  8  SPI command byte
- `req_addr_i`  in  32  SPI address
- `req_wdata_i`  in  32  write data, ignored for reads
- `req_csn_i`  in  2  chip-select index 0..3
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  response consumed
- `rsp_rdata_o`  out  32  read data; 0 for writes
- `rsp_err_o`  out  1  PSLVERR seen or poll timeout
- `paddr_o`  out  APB_ADDR_WIDTH  APB address
- `pwdata_o`  out  32  APB write data
- `pwrite_o`  out  1  APB write
- `psel_o`  out  1  APB select
- `penable_o`  out  1  APB enable
- `prdata_i`  in  32  APB read data
- `pready_i`  in  1  APB ready
- `pslverr_i`  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS, POLL_SETUP, POLL_ACCESS, RESP. A step counter selects the current APB access.
- IDLE: `req_ready_o` = 1. On `req_valid_i` & `req_ready_o`, capture all `req_*` fields, clear the error and rdata registers, then go to SETUP for step 0.
- Write request steps:
  - SPICMD 0x08 ← `{cmd,24'h0}`
  - SPIADR 0x0C ← addr
  - SPILEN 0x10 ← `{16'd32, 8'd32, 8'd8}` (data, addr and cmd bit lengths)
  - TXFIFO 0x18 ← wdata
  - STATUS 0x00 ← `(1 << (8+csn)) | 32'h2`
  - then polling
- Read request steps:
  - SPICMD, SPIADR and SPILEN, as for writes
  - STATUS ← `(1 << (8+csn)) | 32'h1`
  - then polling
  - then RXFIFO 0x20 read, with `prdata_i` latched into `rsp_rdata_o`
- Poll: repeated reads of STATUS 0x00. Transfer is done when `prdata_i[0]` = 1 (SPI master idle). Otherwise issue the next poll read immediately.
- Any access completing with `pslverr_i` = 1: set err, abort remaining steps, go to RESP. No further APB access is issued.
- RESP: `rsp_valid_o` = 1 and held, with data/err stable, until `rsp_ready_i`; then return to IDLE.
- Reset mid-operation: all state is dropped and APB outputs go low in the same cycle (asynchronous). No recovery access is issued.

## Timing
- Reset values:
  - `req_ready_o` = 1
  - `rsp_valid_o`, `rsp_err_o`, `psel_o`, `penable_o` and `pwrite_o` = 0
  - `paddr_o`, `pwdata_o` and `rsp_rdata_o` = 0
- APB protocol:
  - SETUP: one cycle with `psel_o` = 1, `penable_o` = 0.
  - ACCESS: `psel_o` = `penable_o` = 1. `paddr_o`, `pwdata_o` and `pwrite_o` are stable from SETUP until the cycle `pready_i` = 1.
  - The next SETUP follows on the cycle after the completing ACCESS (no idle gap). `psel_o` stays high across back-to-back accesses.
- Zero-wait-state latency from request accept to `rsp_valid_o`, with the first poll reporting idle:
  - write: 6 accesses × 2 = 12 cycles, +1 RESP entry = 13
  - read: 6 accesses × 2 (including RXFIFO) = 12, +1 = 13
- `req_ready_o` is low from the cycle after accept until the cycle after the response handshake.
- A response handshake and a new request cannot coincide, because `req_ready_o` is 0 in RESP.

## Configuration
- `SPI_XFER_SEQ_TIMEOUT_EN` defined:
  - A poll counter counts completed STATUS polls.
  - On the POLL_MAX-th non-idle poll, set err and go to RESP. Read requests skip the RXFIFO access; `rsp_rdata_o` = 0.
- Macro undefined: no counter; polling continues indefinitely.

## Test plan
- Write: cmd 0x02, addr 0x0000_1000, wdata 0xDEAD_BEEF, csn 1, zero-wait, first poll idle -> APB writes in this order:
  - 0x08 ← 0x0200_0000
  - 0x0C ← 0x0000_1000
  - 0x10 ← 0x0020_2008
  - 0x18 ← 0xDEAD_BEEF
  - 0x00 ← 0x0000_0202
  - then one read of 0x00
  - `rsp_valid_o` 13 cycles after accept, `rsp_err_o` = 0
- Read: cmd 0x03, csn 0, STATUS returns 0x04, 0x04, then 0x01, RXFIFO returns 0xA5A5_1234 -> exactly three STATUS polls, then one read of 0x20; `rsp_rdata_o` = 0xA5A5_1234.
- `pslverr_i` = 1 on the SPIADR write -> no further APB accesses; `rsp_err_o` = 1; `rsp_rdata_o` = 0.
- With `SPI_XFER_SEQ_TIMEOUT_EN` and `POLL_MAX` = 4, STATUS always 0x04 -> exactly 4 polls, no RXFIFO read, `rsp_err_o` = 1. Without the macro, polling still continues after 100 polls.
- `pready_i` held low 3 cycles on each access plus `rsp_ready_i` held low 5 cycles -> APB signals stable across wait states; `rsp_valid_o`/data held; `req_ready_o` rises only after the handshake.
- `rst_ni` asserted during the TXFIFO ACCESS -> `psel_o`/`penable_o` drop immediately. After release, `req_ready_o` = 1 and a new request starts with an SPICMD access.
